uge_thresh_detect: RTL
======================

UGE_THRESH_DETECT -- requirements
Module: uge_thresh_detect

Interface
REQ-001 SHALL have parameter WIDTH, default 4: sample/threshold width in bits (2..16).
REQ-002 SHALL have parameter COUNT, default 3: consecutive qualifying samples needed to change state (1..15).
REQ-003 SHALL have port CLK, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port ASYNCRESETN, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port I_VALID, input, 1: I carries a sample this cycle.
REQ-006 SHALL have port I, input, WIDTH: unsigned sample.
REQ-007 SHALL have port TH_LOAD, input, 1: capture TH (and TL when configured) this cycle.
REQ-008 SHALL have port TH, input, WIDTH: unsigned upper threshold.
REQ-009 SHALL have port TL, input, WIDTH: unsigned lower threshold; present only with UGE_THRESH_HYST_EN.
REQ-010 SHALL have port O, output, 1: registered alarm level.
REQ-011 SHALL have port O_RISE, output, 1: one-cycle pulse when O goes 0->1.
REQ-012 SHALL have port O_FALL, output, 1: one-cycle pulse when O goes 1->0.
REQ-013 SHALL have port CNT, output, 4: current qualifying-run count.

Function
REQ-014 SHALL compare unsigned: assert condition pass = (I >= th_reg); release condition fail = (I < th_reg), or (I < tl_reg) with hysteresis.
REQ-015 SHALL implement states LOW, PEND_HI, HIGH, PEND_LO; O = 1 exactly in HIGH and PEND_LO.
REQ-016 SHALL, in LOW on valid pass, set CNT=1 and go PEND_HI (or HIGH directly if COUNT==1); valid non-pass holds LOW, CNT=0.
REQ-017 SHALL, in PEND_HI, increment CNT per valid pass; on reaching COUNT go HIGH, CNT=0; valid non-pass returns LOW, CNT=0.
REQ-018 SHALL, in HIGH on valid release condition, set CNT=1 and go PEND_LO (or LOW if COUNT==1); otherwise hold.
REQ-019 SHALL, in PEND_LO, increment CNT per valid release; on reaching COUNT go LOW, CNT=0; valid non-release returns HIGH, CNT=0.
REQ-020 SHALL hold state and CNT on cycles with I_VALID=0; invalid cycles do not break a run.
REQ-021 SHALL assert O in the cycle after the edge sampling the COUNT-th qualifying sample (latency 1 cycle from that edge).
REQ-022 SHALL pulse O_RISE/O_FALL high for exactly the first cycle O shows its new value; never both high.
REQ-023 SHALL, on TH_LOAD, capture TH (and TL) at the edge; a sample in the same cycle is compared against the old threshold.
REQ-024 SHALL not reset CNT or state on TH_LOAD; a threshold change affects only subsequent samples.
REQ-025 SHALL saturate CNT at COUNT (never wrap).

Reset
REQ-026 SHALL, on ASYNCRESETN low, immediately force state LOW, O=0, O_RISE=0, O_FALL=0, CNT=0, th_reg=all ones, tl_reg=all ones.
REQ-027 SHALL abandon any pending run on reset mid-operation, with no O_FALL pulse.
REQ-028 SHALL resume operation at the first rising CLK edge after ASYNCRESETN deasserts.

Configuration
REQ-029 SHALL, with UGE_THRESH_HYST_EN defined, add port TL and register tl_reg, using I < tl_reg as the release condition.
REQ-030 SHALL, without UGE_THRESH_HYST_EN, omit TL and tl_reg and use I < th_reg as the release condition.

Verification (WIDTH=4, COUNT=3)
REQ-031 SHALL cover reset: ASYNCRESETN low mid-cycle -> O=0 and CNT=0 without waiting for CLK.
REQ-032 SHALL cover assert: TH_LOAD with TH=8, then valid samples 8,9,15 -> O=1 and O_RISE=1 the cycle after the 3rd sample; O_RISE=0 the next cycle.
REQ-033 SHALL cover a broken run: TH=8, samples 9,9,7,9 -> O stays 0; CNT sequence 1,2,0,1.
REQ-034 SHALL cover gaps: TH=8, samples 9,(invalid x2),9,9 -> O=1 after the 3rd valid sample.
REQ-035 SHALL cover hysteresis: macro on, TH=8, TL=4, O=1, samples 6,6,6 -> O stays 1; samples 3,3,3 -> O=0 with O_FALL pulse.
REQ-036 SHALL cover same-cycle load: TH=15, O=0, TH_LOAD with TH=2 together with sample 5 -> CNT stays 0; next sample 5 -> CNT=1.

Source files
------------

// File: rtl/uge_thresh_detect.sv
// rtl/uge_thresh_detect.sv - debounced threshold alarm with optional hysteresis (UGE_THRESH_HYST_EN)
module uge_thresh_detect #(
    parameter int WIDTH = 4,
    parameter int COUNT = 3
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic             I_VALID,
    input  logic [WIDTH-1:0] I,
    input  logic             TH_LOAD,
    input  logic [WIDTH-1:0] TH,
`ifdef UGE_THRESH_HYST_EN
    input  logic [WIDTH-1:0] TL,
`endif
    output logic             O,
    output logic             O_RISE,
    output logic             O_FALL,
    output logic [3:0]       CNT
);

    typedef enum logic [1:0] {
        S_LOW     = 2'd0,
        S_PEND_HI = 2'd1,
        S_HIGH    = 2'd2,
        S_PEND_LO = 2'd3
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(COUNT);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] th_q;
    logic             o_q, o_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             pass;
    logic             release_c;
    logic [3:0]       cnt_inc;

`ifdef UGE_THRESH_HYST_EN
    logic [WIDTH-1:0] tl_q;

    // Lower threshold register, loaded together with the upper one
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            tl_q <= '1;
        end else if (TH_LOAD) begin
            tl_q <= TL;
        end
    end

    assign release_c = (I < tl_q);
`else
    assign release_c = (I < th_q);
`endif

    assign pass = (I >= th_q);

    // Saturating run counter increment; it never wraps past COUNT
    assign cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;

    // Upper threshold register; a same-cycle sample still sees the old value
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            th_q <= '1;
        end else if (TH_LOAD) begin
            th_q <= TH;
        end
    end

    // State, run counter and registered outputs
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= S_LOW;
            cnt_q   <= 4'd0;
            o_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: runs advance only on valid samples, invalid cycles hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (I_VALID) begin
            unique case (state_q)
                S_LOW: begin
                    if (pass) begin
                        if (CNT_MAX == 4'd1) begin
                            state_d = S_HIGH;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = S_PEND_HI;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                S_PEND_HI: begin
                    if (pass) begin
                        if (cnt_inc >= CNT_MAX) begin
                            state_d = S_HIGH;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_LOW;
                        cnt_d   = 4'd0;
                    end
                end
                S_HIGH: begin
                    if (release_c) begin
                        if (CNT_MAX == 4'd1) begin
                            state_d = S_LOW;
                            cnt_d   = 4'd0;
                        end else begin
                            state_d = S_PEND_LO;
                            cnt_d   = 4'd1;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                S_PEND_LO: begin
                    if (release_c) begin
                        if (cnt_inc >= CNT_MAX) begin
                            state_d = S_LOW;
                            cnt_d   = 4'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = 4'd0;
                end
            endcase
        end
        o_d    = (state_d == S_HIGH) || (state_d == S_PEND_LO);
        rise_d = o_d & ~o_q;
        fall_d = ~o_d & o_q;
    end

    assign O      = o_q;
    assign O_RISE = rise_q;
    assign O_FALL = fall_q;
    assign CNT    = cnt_q;

endmodule
